sfp_accum: RTL and testbench

Special-function stage directly downstream of the psum SRAM (SRAM1). It consumes psum rows read from SRAM1 and accumulates them per output column across tiles into wider signed accumulators. It then scans the columns for the largest accumulated distance, the furthest candidate. It holds the result vector plus the argmax until the consumer accepts it.

---
 rtl/sfp_accum.sv | 179 +++++++++++++++++
 tb/tb_sfp_accum.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfp_accum.sv
// sfp_accum
// ---------------------------------------------------------------------------
// Special-function stage that sits directly after the psum SRAM (SRAM1).
// Psum rows read from SRAM1 are summed per output column, across tiles, into
// wider signed accumulators that saturate instead of wrapping. When the last
// row arrives, the columns are scanned one per cycle to find the largest
// accumulated value (the furthest candidate). The accumulated vector and that
// argmax are then held until the consumer accepts them.
//
// Ports
//   clk          clock
//   reset        synchronous active-high reset (aborts any operation)
//   acc_start    pulse: clear accumulators and begin an accumulation (IDLE only)
//   psum_valid   psum_in carries a valid row this cycle
//   psum_last    with psum_valid: final row of this accumulation
//   psum_in      col signed lanes of psum_bw bits, lane i at [psum_bw*i +: psum_bw]
//   out_ready    consumer accepts the held result
//   out_valid    result is held on the outputs
//   out_data     col signed accumulator lanes of acc_bw bits, same packing
//   out_max_val  largest signed lane of out_data
//   out_max_idx  lane index of out_max_val (lowest index on ties)
//   busy         block is not idle
//   ovf          sticky: some lane saturated during the current accumulation
// ---------------------------------------------------------------------------
module sfp_accum #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int acc_bw  = 24
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      acc_start,
  input  logic                      psum_valid,
  input  logic                      psum_last,
  input  logic [psum_bw*col-1:0]    psum_in,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [acc_bw*col-1:0]     out_data,
  output logic [acc_bw-1:0]         out_max_val,
  output logic [$clog2(col)-1:0]    out_max_idx,
  output logic                      busy,
  output logic                      ovf
);

  localparam int idx_w = $clog2(col);

  localparam logic [acc_bw-1:0] acc_max = {1'b0, {(acc_bw-1){1'b1}}};
  localparam logic [acc_bw-1:0] acc_min = {1'b1, {(acc_bw-1){1'b0}}};
  localparam logic [idx_w-1:0]  last_idx = idx_w'(col - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    SCAN = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t                    state_q;
  state_t                    state_d;

  logic signed [acc_bw-1:0]  acc_q    [col];
  logic signed [acc_bw:0]    sum_w    [col];
  logic signed [acc_bw-1:0]  acc_sat  [col];
  logic [col-1:0]            lane_clamp;

  logic [idx_w-1:0]          scan_idx_q;
  logic signed [acc_bw-1:0]  max_val_q;
  logic [idx_w-1:0]          max_idx_q;
  logic                      ovf_q;

  logic signed [acc_bw-1:0]  scan_val;
  logic                      scan_gt;

  // Per-lane saturating add. The sum is formed one bit wider than the
  // accumulator; if the top two bits disagree the true result does not fit,
  // and the top bit tells which rail to clamp to.
  always_comb begin
    for (int i = 0; i < col; i++) begin
      sum_w[i] = {acc_q[i][acc_bw-1], acc_q[i]}
               + {{(acc_bw+1-psum_bw){psum_in[psum_bw*i + psum_bw - 1]}},
                  psum_in[psum_bw*i +: psum_bw]};
      lane_clamp[i] = sum_w[i][acc_bw] ^ sum_w[i][acc_bw-1];
      if (lane_clamp[i]) begin
        acc_sat[i] = sum_w[i][acc_bw] ? acc_min : acc_max;
      end else begin
        acc_sat[i] = sum_w[i][acc_bw-1:0];
      end
    end
  end

  // The scan compares one lane per cycle against the running maximum. The
  // comparison is strict so that an equal value at a higher lane never
  // displaces an earlier one.
  always_comb begin
    scan_val = acc_q[scan_idx_q];
    scan_gt  = (scan_val > max_val_q);
  end

  // Next-state logic. Starts outside IDLE and rows outside ACC fall through
  // to the hold-state default and are therefore dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (acc_start)               state_d = ACC;
      ACC:  if (psum_valid && psum_last) state_d = SCAN;
      SCAN: if (scan_idx_q == last_idx)  state_d = HOLD;
      HOLD: if (out_ready)               state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  // Datapath and state registers. The accumulators are only cleared by a
  // start or by reset, so out_data keeps the last result after the handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      scan_idx_q <= '0;
      max_val_q  <= '0;
      max_idx_q  <= '0;
      ovf_q      <= 1'b0;
      for (int i = 0; i < col; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (acc_start) begin
            ovf_q <= 1'b0;
            for (int i = 0; i < col; i++) begin
              acc_q[i] <= '0;
            end
          end
        end
        ACC: begin
          if (psum_valid) begin
            for (int i = 0; i < col; i++) begin
              acc_q[i] <= acc_sat[i];
            end
            if (|lane_clamp) begin
              ovf_q <= 1'b1;
            end
            // The final row is folded in on this same edge; the scan starts
            // next cycle from the most-negative value so lane 0 always wins
            // or ties.
            if (psum_last) begin
              scan_idx_q <= '0;
              max_val_q  <= acc_min;
              max_idx_q  <= '0;
            end
          end
        end
        SCAN: begin
          if (scan_gt) begin
            max_val_q <= scan_val;
            max_idx_q <= scan_idx_q;
          end
          scan_idx_q <= scan_idx_q + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < col; i++) begin
      out_data[acc_bw*i +: acc_bw] = acc_q[i];
    end
  end

  assign out_valid   = (state_q == HOLD);
  assign busy        = (state_q != IDLE);
  assign out_max_val = max_val_q;
  assign out_max_idx = max_idx_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_sfp_accum.sv
// tb_sfp_accum
// ---------------------------------------------------------------------------
// Two instances share every input: one with 24-bit accumulators and one with
// 17-bit accumulators, so saturation is reachable with a handful of rows.
// A behavioural model (plain integer sums with clamping, linear argmax)
// predicts the results of both.
// ---------------------------------------------------------------------------
module tb_sfp_accum;

  localparam int PB  = 16;
  localparam int COL = 8;
  localparam int AW0 = 24;
  localparam int AW1 = 17;
  localparam int IW  = 3;

  logic               clk = 1'b0;
  logic               reset;
  logic               acc_start;
  logic               psum_valid;
  logic               psum_last;
  logic [PB*COL-1:0]  psum_in;
  logic               out_ready;

  logic               ov0, busy0, ovf0;
  logic [AW0*COL-1:0] od0;
  logic [AW0-1:0]     omv0;
  logic [IW-1:0]      omi0;

  logic               ov1, busy1, ovf1;
  logic [AW1*COL-1:0] od1;
  logic [AW1-1:0]     omv1;
  logic [IW-1:0]      omi1;

  int     errors = 0;
  int     checks = 0;
  longint m_acc [2][COL];
  bit     m_ovf [2];
  int     rows  [16][COL];

  always #5 clk = ~clk;

  sfp_accum #(.psum_bw(PB), .col(COL), .acc_bw(AW0)) dut0 (
    .clk(clk), .reset(reset), .acc_start(acc_start), .psum_valid(psum_valid),
    .psum_last(psum_last), .psum_in(psum_in), .out_ready(out_ready),
    .out_valid(ov0), .out_data(od0), .out_max_val(omv0), .out_max_idx(omi0),
    .busy(busy0), .ovf(ovf0)
  );

  sfp_accum #(.psum_bw(PB), .col(COL), .acc_bw(AW1)) dut1 (
    .clk(clk), .reset(reset), .acc_start(acc_start), .psum_valid(psum_valid),
    .psum_last(psum_last), .psum_in(psum_in), .out_ready(out_ready),
    .out_valid(ov1), .out_data(od1), .out_max_val(omv1), .out_max_idx(omi1),
    .busy(busy1), .ovf(ovf1)
  );

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int aw(input int inst);
    return (inst == 0) ? AW0 : AW1;
  endfunction

  function automatic logic [255:0] trunc(input longint v, input int w);
    logic [255:0] r;
    r = '0;
    for (int b = 0; b < w; b++) r[b] = v[b];
    return r;
  endfunction

  function automatic logic [255:0] pack_data(input int inst);
    logic [255:0] r;
    int w;
    w = aw(inst);
    r = '0;
    for (int i = 0; i < COL; i++)
      for (int b = 0; b < w; b++)
        r[w*i + b] = m_acc[inst][i][b];
    return r;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_ovf[k] = 1'b0;
      for (int i = 0; i < COL; i++) m_acc[k][i] = 0;
    end
  endtask

  task automatic model_row(input int r);
    longint s, lim;
    for (int k = 0; k < 2; k++) begin
      lim = longint'(1) << (aw(k) - 1);
      for (int i = 0; i < COL; i++) begin
        s = m_acc[k][i] + longint'(r);
        s = m_acc[k][i] + longint'(rows[r][i]);
        if (s > lim - 1) begin s = lim - 1; m_ovf[k] = 1'b1; end
        if (s < -lim)    begin s = -lim;    m_ovf[k] = 1'b1; end
        m_acc[k][i] = s;
      end
    end
  endtask

  task automatic model_max(input int inst, output longint v, output int idx);
    v = m_acc[inst][0];
    idx = 0;
    for (int i = 1; i < COL; i++)
      if (m_acc[inst][i] > v) begin v = m_acc[inst][i]; idx = i; end
  endtask

  task automatic checkAll(input string tag);
    longint v;
    int idx;
    model_max(0, v, idx);
    checkOutput({tag, "_data24"},   256'(od0),  pack_data(0));
    checkOutput({tag, "_maxval24"}, 256'(omv0), trunc(v, AW0));
    checkOutput({tag, "_maxidx24"}, 256'(omi0), 256'(idx));
    checkOutput({tag, "_ovf24"},    256'(ovf0), 256'(m_ovf[0]));
    model_max(1, v, idx);
    checkOutput({tag, "_data17"},   256'(od1),  pack_data(1));
    checkOutput({tag, "_maxval17"}, 256'(omv1), trunc(v, AW1));
    checkOutput({tag, "_maxidx17"}, 256'(omi1), 256'(idx));
    checkOutput({tag, "_ovf17"},    256'(ovf1), 256'(m_ovf[1]));
  endtask

  task automatic drive_row(input int r);
    for (int i = 0; i < COL; i++) psum_in[PB*i +: PB] = rows[r][i][PB-1:0];
  endtask

  // One full transaction: start, rows (optionally with idle gaps carrying
  // ignored starts), latency measurement, result check, then either an
  // immediate accept or a stall of `hold` cycles with junk inputs.
  task automatic applyStimulus(input int nrows, input int hold, input bit gaps);
    int cnt;
    out_ready = (hold == 0);
    acc_start = 1'b1;
    tick();
    acc_start = 1'b0;
    model_clear();
    checkOutput("busy_after_start", 256'({busy1, busy0}), 256'(2'b11));
    checkOutput("ovf_cleared", 256'({ovf1, ovf0}), 256'(0));
    for (int r = 0; r < nrows; r++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        psum_valid = 1'b0;
        psum_last  = 1'b1;
        acc_start  = 1'($urandom_range(0, 1));
        tick();
        acc_start  = 1'b0;
      end
      drive_row(r);
      psum_valid = 1'b1;
      psum_last  = (r == nrows - 1);
      tick();
      model_row(r);
    end
    psum_valid = 1'b0;
    psum_last  = 1'b0;
    cnt = 0;
    while (ov0 !== 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    checkOutput("latency", 256'(cnt), 256'(COL));
    checkOutput("valid17", 256'(ov1), 256'(1));
    checkAll("result");
    if (hold == 0) begin
      tick();
      checkOutput("valid_one_cycle", 256'({ov1, ov0}), 256'(0));
    end else begin
      for (int h = 0; h < hold; h++) begin
        acc_start  = 1'($urandom_range(0, 1));
        psum_valid = 1'($urandom_range(0, 1));
        psum_last  = 1'($urandom_range(0, 1));
        psum_in    = {$urandom, $urandom, $urandom, $urandom};
        tick();
        checkOutput("hold_valid", 256'({ov1, ov0}), 256'(2'b11));
        checkAll("hold");
      end
      psum_valid = 1'b0;
      psum_last  = 1'b0;
      out_ready  = 1'b1;
      acc_start  = 1'b1;
      tick();
      out_ready  = 1'b0;
      acc_start  = 1'b0;
      checkOutput("valid_drop", 256'({ov1, ov0}), 256'(0));
      checkOutput("idle_after_accept", 256'({busy1, busy0}), 256'(0));
      checkAll("retained");
      tick();
      checkOutput("start_at_handshake_ignored", 256'({busy1, busy0}), 256'(0));
    end
  endtask

  function automatic int rand_lane();
    logic signed [15:0] t;
    case ($urandom_range(0, 5))
      0:       t = 16'sh7FFF;
      1:       t = 16'sh8000;
      default: t = 16'($urandom);
    endcase
    return int'(t);
  endfunction

  initial begin
    int n;
    reset      = 1'b1;
    acc_start  = 1'b0;
    psum_valid = 1'b0;
    psum_last  = 1'b0;
    psum_in    = '0;
    out_ready  = 1'b0;
    model_clear();
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state and rows ignored while idle
    checkOutput("reset_valid", 256'({ov1, ov0}), 256'(0));
    checkOutput("reset_busy", 256'({busy1, busy0}), 256'(0));
    checkAll("reset");
    for (int k = 0; k < 3; k++) begin
      psum_in    = {$urandom, $urandom, $urandom, $urandom};
      psum_valid = 1'b1;
      psum_last  = 1'($urandom_range(0, 1));
      tick();
    end
    psum_valid = 1'b0;
    psum_last  = 1'b0;
    checkAll("idle_rows_ignored");
    checkOutput("idle_busy", 256'({busy1, busy0}), 256'(0));

    // Ramp rows, consumer always ready
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < COL; i++) rows[r][i] = i + 1;
    applyStimulus(3, 0, 1'b0);
    checkOutput("ramp_idx", 256'(omi0), 256'(7));
    checkOutput("ramp_max", 256'(omv0), 256'(24));

    // Signed values with a tie for the maximum
    rows[0] = '{-5, 7, 7, -32768, 0, 3, 7, -1};
    applyStimulus(1, 0, 1'b0);
    checkOutput("tie_max", 256'(omv0), 256'(7));
    checkOutput("tie_idx", 256'(omi0), 256'(1));
    checkOutput("neg_lane3", 256'(od0[3*AW0 +: AW0]), 256'(24'hFF8000));

    // Saturation on the 17-bit instance
    for (int r = 0; r < 5; r++)
      for (int i = 0; i < COL; i++) rows[r][i] = (i == 0) ? 32767 : rand_lane();
    applyStimulus(5, 0, 1'b0);
    checkOutput("sat_lane0", 256'(od1[AW1-1:0]), 256'(17'h0FFFF));
    checkOutput("sat_ovf17", 256'(ovf1), 256'(1));
    checkOutput("sat_ovf24", 256'(ovf0), 256'(0));

    // Backpressure for 20 cycles (its start also proves ovf is cleared)
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < COL; i++) rows[r][i] = rand_lane();
    applyStimulus(4, 20, 1'b1);

    // Random transactions
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(1, 12);
      for (int r = 0; r < n; r++)
        for (int i = 0; i < COL; i++) rows[r][i] = rand_lane();
      applyStimulus(n, $urandom_range(0, 4), 1'b1);
    end

    // Reset in the middle of an accumulation, then a clean one-row pass
    out_ready = 1'b0;
    acc_start = 1'b1;
    tick();
    acc_start = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < COL; i++) rows[r][i] = rand_lane();
      drive_row(r);
      psum_valid = 1'b1;
      tick();
    end
    psum_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_clear();
    checkOutput("abort_busy", 256'({busy1, busy0}), 256'(0));
    checkOutput("abort_valid", 256'({ov1, ov0}), 256'(0));
    checkAll("abort");
    for (int i = 0; i < COL; i++) rows[0][i] = 1;
    applyStimulus(1, 0, 1'b0);
    checkOutput("fresh_lane7", 256'(od0[7*AW0 +: AW0]), 256'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
